if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
- IF stage of the 5-stage MIPS pipeline: PC register, instruction-memory request, and the IF/ID pipeline register.
- Consumes the ID-stage branch decision (branch taken + target) and jump redirect. Honours hazard-unit stall. Feeds the ID stage, where the branch comparator and decoder sit.
- Handles a not-ready instruction memory with a small state machine.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded at reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  input  1  pipeline clock; all state changes on rising edge.
- rstn  input  1  asynchronous, active-low reset.
- stall  input  1  hazard unit: hold PC and IF/ID.
- branch  input  1  ID-stage branch-taken.
- branch_target  input  32  ID-computed branch target.
- jump  input  1  ID-stage j/jal/jr redirect.
- jump_target  input  32  ID-computed jump target.
- imem_addr  output  32  fetch address; equals PC.
- imem_req  output  1  fetch request valid.
- imem_ready  input  1  imem_rdata valid for imem_addr this cycle.
- imem_rdata  input  32  fetched instruction word.
- if_id_pc  output  32  PC of the instruction in IF/ID.
- if_id_pc4  output  32  if_id_pc + PC_STEP.
- if_id_instr  output  32  instruction in IF/ID; 32'h0 (sll $0 NOP) for a bubble.
- if_id_valid  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset (rstn=0, asynchronous):
  - PC=RESET_PC; state=BOOT.
  - if_id_pc=0, if_id_pc4=0, if_id_instr=0, if_id_valid=0; imem_req=0.
- States:
  - BOOT: one cycle after rstn deasserts; imem_req=0; unconditionally goes to RUN. stall, branch and jump are ignored in BOOT.
  - RUN: imem_req=1, imem_addr=PC.
  - WAIT: entered from RUN when imem_ready=0 and no stall/redirect. imem_req stays 1 at the same PC. Returns to RUN on imem_ready=1.
- Redirect is branch OR jump. Target select: branch_target when branch=1, else jump_target. Branch wins if both are asserted.
- Priority per edge: stall > redirect > fetch.
- stall=1:
  - PC, IF/ID and state are held.
  - branch/jump are ignored, because the ID instruction is held and is re-evaluated after the stall releases.
  - imem_req stays 1; any imem response is discarded.
- Redirect, no stall:
  - PC <= target.
  - IF/ID <= bubble (valid=0, instr=0, pc/pc4 held), since the IF instruction is wrong-path.
  - State goes to RUN, even from WAIT; a pending miss is abandoned.
  - The taken-branch penalty is 1 bubble.
- Fetch, no stall/redirect, imem_ready=1:
  - IF/ID <= {PC, PC+PC_STEP, imem_rdata, valid=1}.
  - PC <= PC+PC_STEP.
  - Latency: address presented in cycle N, instruction visible on if_id_* in cycle N+1.
- Fetch, no stall/redirect, imem_ready=0: IF/ID <= bubble; PC held; state=WAIT.
- Arithmetic:
  - PC arithmetic is 32-bit modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0, with no flag.
  - PC[1:0] is forced to 00 on every load, including targets.
- Reset mid-operation (any state) returns to BOOT immediately, with no wait for a clock edge.

Optional Feature:
- Macro: BRANCH_DELAY_SLOT_EN.
- Defined:
  - MIPS delay-slot semantics: on a redirect, the instruction currently in IF is kept.
  - If imem_ready=1, IF/ID loads it normally as the delay slot (valid=1) and PC <= target.
  - If imem_ready=0, PC stays at the delay-slot address; a redirect-pending flag stores the target.
  - After the delay slot is accepted, PC <= stored target.
- Undefined: flush-on-redirect as described in Behaviour.

Test Plan:
- Reset then imem_ready=1 constant:
  - BOOT 1 cycle.
  - imem_addr sequence 0x3000, 0x3004, 0x3008.
  - if_id_pc 0x3000 one cycle after the first fetch, valid=1.
- branch=1 with branch_target=0x3040 while PC=0x3008:
  - Next cycle PC=0x3040; if_id_valid=0, if_id_instr=0.
  - Following cycle if_id_pc=0x3040.
  - With BRANCH_DELAY_SLOT_EN: if_id_pc=0x3008, valid=1, then 0x3040.
- stall=1 for 3 cycles with branch=1 and imem_ready=1:
  - PC and all if_id_* outputs are unchanged for all 3 cycles.
  - Redirect is taken only on the first cycle with stall=0.
- imem_ready=0 for 2 cycles at PC=0x300C:
  - Two bubbles; state WAIT; imem_addr stays 0x300C.
  - On ready, if_id_pc=0x300C, valid=1.
- jump to 0x0040_0000 during WAIT: PC=0x0040_0000, state RUN, the old miss is dropped. Then branch and jump together: branch_target wins.
- rstn pulsed low mid-WAIT: outputs return to reset values asynchronously. PC=0x3000 after release. Also check wrap: PC 0xFFFF_FFFC fetches, then PC=0x0.

Source files
------------

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the PC, issues
// instruction-memory requests, and owns the IF/ID pipeline register. A small
// FSM (BOOT/RUN/WAIT) covers the first cycle out of reset and an instruction
// memory that is not ready.
//
// Ports:
//   clk            pipeline clock, all state changes on the rising edge
//   rstn           asynchronous active-low reset
//   stall          hazard unit: hold PC, IF/ID and FSM state
//   branch         ID-stage branch taken
//   branch_target  ID-computed branch target
//   jump           ID-stage j/jal/jr redirect
//   jump_target    ID-computed jump target
//   imem_addr      fetch address (always the PC)
//   imem_req       fetch request valid (low only in BOOT)
//   imem_ready     imem_rdata is valid for imem_addr this cycle
//   imem_rdata     fetched instruction word
//   if_id_pc       PC of the instruction held in IF/ID
//   if_id_pc4      if_id_pc + PC_STEP
//   if_id_instr    instruction in IF/ID, 32'h0 (sll $0 NOP) for a bubble
//   if_id_valid    IF/ID holds a real instruction
//
// Optional feature, macro BRANCH_DELAY_SLOT_EN:
//   Defined   : MIPS delay-slot semantics. On a redirect the instruction in
//               IF is kept and enters IF/ID as the delay slot. If the memory
//               is not ready, the target is parked in a redirect-pending
//               register and applied once the delay slot is accepted.
//   Undefined : flush-on-redirect, the IF instruction is replaced by a
//               bubble and the PC jumps to the target immediately.
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t      state_q,       state_d;
  logic [31:0] pc_q,          pc_d;
  logic [31:0] if_id_pc_q,    if_id_pc_d;
  logic [31:0] if_id_pc4_q,   if_id_pc4_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
`ifdef BRANCH_DELAY_SLOT_EN
  logic        pend_q,        pend_d;
  logic [31:0] pend_tgt_q,    pend_tgt_d;
`endif

  logic        redirect;
  logic [31:0] redirect_tgt;
  logic [31:0] pc_seq;

  // Branch wins over jump when both are raised. Every PC load is forced to a
  // word boundary, targets included.
  assign redirect     = branch | jump;
  assign redirect_tgt = (branch ? branch_target : jump_target) & 32'hFFFF_FFFC;
  assign pc_seq       = (pc_q + PC_STEP) & 32'hFFFF_FFFC;

  // Priority on each edge is stall > redirect > fetch; BOOT ignores all of it.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
`ifdef BRANCH_DELAY_SLOT_EN
    pend_d        = pend_q;
    pend_tgt_d    = pend_tgt_q;
`endif

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end

      ST_RUN, ST_WAIT: begin
        if (!stall) begin
`ifdef BRANCH_DELAY_SLOT_EN
          if (imem_ready) begin
            // The word in IF is accepted, whether it is a delay slot or not.
            if_id_pc_d    = pc_q;
            if_id_pc4_d   = pc_q + PC_STEP;
            if_id_instr_d = imem_rdata;
            if_id_valid_d = 1'b1;
            state_d       = ST_RUN;
            if (pend_q) begin
              pc_d   = pend_tgt_q;
              pend_d = 1'b0;
            end else if (redirect) begin
              pc_d = redirect_tgt;
            end else begin
              pc_d = pc_seq;
            end
          end else begin
            // PC stays on the delay-slot address until it arrives.
            if_id_instr_d = 32'h0;
            if_id_valid_d = 1'b0;
            state_d       = ST_WAIT;
            if (redirect && !pend_q) begin
              pend_d     = 1'b1;
              pend_tgt_d = redirect_tgt;
            end
          end
`else
          if (redirect) begin
            // Wrong-path instruction in IF is squashed; any pending miss is
            // abandoned.
            pc_d          = redirect_tgt;
            if_id_instr_d = 32'h0;
            if_id_valid_d = 1'b0;
            state_d       = ST_RUN;
          end else if (imem_ready) begin
            if_id_pc_d    = pc_q;
            if_id_pc4_d   = pc_q + PC_STEP;
            if_id_instr_d = imem_rdata;
            if_id_valid_d = 1'b1;
            pc_d          = pc_seq;
            state_d       = ST_RUN;
          end else begin
            if_id_instr_d = 32'h0;
            if_id_valid_d = 1'b0;
            state_d       = ST_WAIT;
          end
`endif
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      if_id_pc_q    <= 32'h0;
      if_id_pc4_q   <= 32'h0;
      if_id_instr_q <= 32'h0;
      if_id_valid_q <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
      pend_q        <= 1'b0;
      pend_tgt_q    <= 32'h0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
`ifdef BRANCH_DELAY_SLOT_EN
      pend_q        <= pend_d;
      pend_tgt_q    <= pend_tgt_d;
`endif
    end
  end

  assign imem_addr   = pc_q;
  assign imem_req    = (state_q != ST_BOOT);
  assign if_id_pc    = if_id_pc_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;

endmodule
